uart_rx_16x: RTL and testbench
==============================

UART_RX_16X -- requirements
Module: uart_rx_16x

Interface
REQ-001 SHALL have parameter PARITY_ODD, default 0, parity sense when parity is compiled in (0 = even, 1 = odd).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tick16  input  1  one-clk-wide strobe at 16x baud rate; all bit timing advances only on tick16=1.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-006 SHALL have port read  input  1  one-clk pulse from the consumer acknowledging rdata.
REQ-007 SHALL have port rdata  output  8  last received byte.
REQ-008 SHALL have port rxrdy  output  1  rdata holds an unread byte.
REQ-009 SHALL have ports parityerr, framingerr, overrun  output  1 each  receive error flags.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; only the synchronized value (rx_s) is used.
REQ-011 SHALL implement the states IDLE, START, DATA, PARITY, STOP, WAITHI.
REQ-012 IDLE: on a tick16 with rx_s=0, SHALL go to START and clear the 4-bit tick counter.
REQ-013 START: at the 8th tick16 (counter=7), SHALL go to DATA if rx_s=0; otherwise SHALL return to IDLE (glitch rejection, no flags change).
REQ-014 DATA: SHALL sample rx_s every 16 ticks at mid-bit, shift LSB first, 8 bits; then SHALL go to PARITY if compiled in, else STOP.
REQ-015 PARITY: SHALL sample the parity bit at mid-bit and compute the error against PARITY_ODD over the 8 data bits plus the parity bit.
REQ-016 STOP: at mid-bit, SHALL load rdata, parityerr and framingerr (framingerr = ~rx_s), set rxrdy; latency is 1 clk after the sampling tick.
REQ-017 After STOP, SHALL go to IDLE if the stop bit was 1, or to WAITHI if it was 0; WAITHI SHALL wait for rx_s=1, then go to IDLE.
REQ-018 If a frame completes while rxrdy=1 and read=0, SHALL set overrun=1 and SHALL NOT overwrite rdata, parityerr or framingerr.
REQ-019 read=1 with rxrdy=1 SHALL clear rxrdy and overrun on the next edge; read with rxrdy=0 SHALL have no effect.
REQ-020 When read=1 and a frame completes on the same edge, the new byte SHALL be loaded, rxrdy SHALL stay 1, and overrun SHALL stay 0.
REQ-021 parityerr/framingerr SHALL hold until the next accepted frame loads new values.
REQ-022 tick16=0 SHALL freeze the counter and FSM; read SHALL still be serviced.

Reset
REQ-023 reset=1 SHALL immediately force IDLE, counters 0, synchronizer flops 1, rdata=0x00, rxrdy=0, parityerr=0, framingerr=0, overrun=0.
REQ-024 Reset mid-frame SHALL discard the partial frame; reception SHALL restart only on a new falling edge after release.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: frame SHALL be start + 8 data + parity + stop, with PARITY state active.
REQ-026 Macro UART_RX_PARITY_EN undefined: frame SHALL be 8N1, PARITY state absent, parityerr tied 0, PARITY_ODD ignored.

Verification
REQ-027 8N1 (macro off), tick16 every clk, send 0xA5 with stop=1 -> rdata=0xA5, rxrdy=1 one clk after the stop mid-sample, all errors 0.
REQ-028 rx low for 4 ticks then high -> FSM back in IDLE, rxrdy=0, no flags.
REQ-029 Send 0x3C with stop=0 -> framingerr=1, rdata=0x3C; hold rx low 40 ticks then send 0x11 -> 0x11 accepted only after rx high.
REQ-030 Send 0x01 then 0x02 without read -> rdata=0x01, overrun=1; a read pulse -> rxrdy=0, overrun=0.
REQ-031 Macro on, PARITY_ODD=0, send 0x07 with parity=0 -> parityerr=1; with parity=1 -> parityerr=0.
REQ-032 Assert reset during DATA bit 4 -> all outputs 0 immediately; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_16x.sv
// 16x-oversampling UART receiver: 8N1 by default, 8-data + parity + stop when
// UART_RX_PARITY_EN is defined (PARITY_ODD selects the sense).
module uart_rx_16x #(
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick16,
  input  logic       rx,
  input  logic       read,
  output logic [7:0] rdata,
  output logic       rxrdy,
  output logic       parityerr,
  output logic       framingerr,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAITHI
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_done;
  logic        accept;
  logic        mid_bit;

  logic [7:0]  rdata_q;
  logic        rxrdy_q, framingerr_q, overrun_q;

`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        parityerr_q;
`else
  // Parity sense has no meaning in the 8N1 build.
  logic        unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign mid_bit = (cnt_q == 4'd15);
  // A completed frame is taken unless an unread byte is still waiting.
  assign accept  = frame_done && (!rxrdy_q || read);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
`endif
    if (tick16) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            cnt_d   = 4'd0;
          end
        end
        START: begin
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            bit_d   = 3'd0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (mid_bit) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt_d = cnt_q + 4'd1;
          if (mid_bit) begin
            par_bad_d = (^shift_q) ^ rx_s_q ^ (PARITY_ODD != 0);
            state_d   = STOP;
          end
        end
`endif
        STOP: begin
          cnt_d = cnt_q + 4'd1;
          if (mid_bit) begin
            frame_done = 1'b1;
            state_d    = rx_s_q ? IDLE : WAITHI;
          end
        end
        WAITHI: begin
          if (rx_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      rdata_q      <= 8'h00;
      rxrdy_q      <= 1'b0;
      framingerr_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parityerr_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
      if (accept) begin
        rdata_q      <= shift_q;
        framingerr_q <= ~rx_s_q;
        rxrdy_q      <= 1'b1;
        overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parityerr_q  <= par_bad_q;
`endif
      end else if (frame_done) begin
        overrun_q <= 1'b1;
      end else if (read && rxrdy_q) begin
        rxrdy_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign rdata      = rdata_q;
  assign rxrdy      = rxrdy_q;
  assign framingerr = framingerr_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parityerr  = parityerr_q;
`else
  assign parityerr  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_16x.sv
// Self-checking bench for uart_rx_16x: directed vector table, timing corner
// sequences and randomized frames against a frame-level reference model.
module tb_uart_rx_16x;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick16 = 1'b1;
  logic       rx = 1'b1;
  logic       read = 1'b0;
  logic [7:0] rdata;
  logic       rxrdy, parityerr, framingerr, overrun;

  int tests  = 0;
  int errors = 0;
  int tick_div = 1;
  int tick_phase = 0;

`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Sync (2) + detect (1) + half start bit (8) + 16 per remaining bit.
  localparam int LAT = 11 + 16 * (9 + PBITS);

  uart_rx_16x dut (
    .clk       (clk),
    .reset     (reset),
    .tick16    (tick16),
    .rx        (rx),
    .read      (read),
    .rdata     (rdata),
    .rxrdy     (rxrdy),
    .parityerr (parityerr),
    .framingerr(framingerr),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_div <= 1) begin
        tick16 = 1'b1;
      end else begin
        tick_phase = (tick_phase + 1) % tick_div;
        tick16 = (tick_phase == 0);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $fatal(1, "watchdog");
  end

  // Frame-level reference model
  logic [7:0] m_rdata;
  logic       m_rxrdy, m_ferr, m_perr, m_ovr;

  task automatic model_reset();
    m_rdata = 8'h00; m_rxrdy = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_read();
    if (m_rxrdy) begin
      m_rxrdy = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop, input logic par);
    if (m_rxrdy) begin
      m_ovr = 1'b1;
    end else begin
      m_rdata = d;
      m_ferr  = !stop;
`ifdef UART_RX_PARITY_EN
      m_perr  = ((($countones(d) + int'(par)) % 2) != 0);
`else
      m_perr  = 1'b0;
      if (par) m_perr = 1'b0;
`endif
      m_rxrdy = 1'b1;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check8({tag, "_rdata"}, rdata, m_rdata);
    check1({tag, "_rxrdy"}, rxrdy, m_rxrdy);
    check1({tag, "_ferr"}, framingerr, m_ferr);
    check1({tag, "_perr"}, parityerr, m_perr);
    check1({tag, "_ovr"}, overrun, m_ovr);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(16 * tick_div);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par) rx = 1'b0;
`endif
    send_bit(stop);
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    wait_clks(n * tick_div);
  endtask

  task automatic pulse_read();
    read = 1'b1;
    wait_clks(1);
    read = 1'b0;
  endtask

  task automatic do_reset();
    tick_div = 1;
    reset = 1'b1;
    rx = 1'b1;
    read = 1'b0;
    wait_clks(3);
    reset = 1'b0;
    model_reset();
    idle_ticks(20);
  endtask

  typedef struct {
    logic       rd;
    logic [7:0] d;
    logic       stop;
    logic [7:0] e_rdata;
    logic       e_rxrdy;
    logic       e_ferr;
    logic       e_ovr;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [7:0] d;
    logic       stop, par;

    vt[0] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
    vt[2] = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b1, 8'h80, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 8'h02, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 8'h55, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1};

    // Reset state
    wait_clks(3);
    check8("rst_rdata", rdata, 8'h00);
    check1("rst_rxrdy", rxrdy, 1'b0);
    check1("rst_ferr", framingerr, 1'b0);
    check1("rst_perr", parityerr, 1'b0);
    check1("rst_ovr", overrun, 1'b0);
    do_reset();

    // Exact output latency relative to the falling start edge
    fork
      send_frame(8'hA5, 1'b1, ^8'hA5);
      begin
        repeat (LAT - 1) @(posedge clk);
        #2;
        check1("lat_before", rxrdy, 1'b0);
        @(posedge clk);
        #2;
        check1("lat_rxrdy", rxrdy, 1'b1);
        check8("lat_rdata", rdata, 8'hA5);
        check1("lat_ferr", framingerr, 1'b0);
        check1("lat_perr", parityerr, 1'b0);
      end
    join
    $display("[TB] latency frame rdata=%02h rxrdy=%b", rdata, rxrdy);
    pulse_read();
    check1("read_clr", rxrdy, 1'b0);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      if (vt[i].rd) pulse_read();
      idle_ticks(6);
      send_frame(vt[i].d, vt[i].stop, ^vt[i].d);
      check8($sformatf("vec%0d_rdata", i), rdata, vt[i].e_rdata);
      check1($sformatf("vec%0d_rxrdy", i), rxrdy, vt[i].e_rxrdy);
      check1($sformatf("vec%0d_ferr", i), framingerr, vt[i].e_ferr);
      check1($sformatf("vec%0d_ovr", i), overrun, vt[i].e_ovr);
      check1($sformatf("vec%0d_perr", i), parityerr, 1'b0);
      $display("[TB] vec%0d sent=%02h stop=%b rdata=%02h rxrdy=%b ferr=%b ovr=%b",
               i, vt[i].d, vt[i].stop, rdata, rxrdy, framingerr, overrun);
    end
    pulse_read();
    check1("ovr_read_rxrdy", rxrdy, 1'b0);
    check1("ovr_read_ovr", overrun, 1'b0);
    check8("ovr_read_rdata", rdata, 8'h01);
    pulse_read();
    check1("idle_read_rxrdy", rxrdy, 1'b0);

    // Framing error, line held low, then recovery only after line goes high
    do_reset();
    send_frame(8'h3C, 1'b0, ^8'h3C);
    check1("fe_flag", framingerr, 1'b1);
    check8("fe_rdata", rdata, 8'h3C);
    pulse_read();
    rx = 1'b0;
    wait_clks(200);
    check1("low_hold_rxrdy", rxrdy, 1'b0);
    check1("low_hold_ferr", framingerr, 1'b1);
    idle_ticks(6);
    send_frame(8'h11, 1'b1, ^8'h11);
    check8("recov_rdata", rdata, 8'h11);
    check1("recov_rxrdy", rxrdy, 1'b1);
    check1("recov_ferr", framingerr, 1'b0);
    $display("[TB] recovery frame rdata=%02h ferr=%b", rdata, framingerr);

    // Short start glitch is rejected
    do_reset();
    rx = 1'b0;
    wait_clks(4);
    idle_ticks(30);
    check1("glitch_rxrdy", rxrdy, 1'b0);
    check1("glitch_ferr", framingerr, 1'b0);
    check1("glitch_ovr", overrun, 1'b0);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    check8("glitch_next_rdata", rdata, 8'h5A);
    check1("glitch_next_rxrdy", rxrdy, 1'b1);

    // Read on the same edge a frame completes
    idle_ticks(6);
    fork
      send_frame(8'hC3, 1'b1, ^8'hC3);
      begin
        repeat (LAT - 1) @(posedge clk);
        #2;
        read = 1'b1;
        @(posedge clk);
        #2;
        read = 1'b0;
      end
    join
    check8("same_edge_rdata", rdata, 8'hC3);
    check1("same_edge_rxrdy", rxrdy, 1'b1);
    check1("same_edge_ovr", overrun, 1'b0);
    $display("[TB] same-edge read frame rdata=%02h ovr=%b", rdata, overrun);

    // Asynchronous reset during data bit 4 (rxrdy still set from C3)
    idle_ticks(6);
    rx = 1'b0;
    wait_clks(16);
    for (int i = 0; i < 4; i++) send_bit(d_bit(8'h5A, i));
    rx = 1'b1;
    wait_clks(8);
    reset = 1'b1;
    #1;
    check1("async_rst_rxrdy", rxrdy, 1'b0);
    check8("async_rst_rdata", rdata, 8'h00);
    check1("async_rst_ovr", overrun, 1'b0);
    check1("async_rst_ferr", framingerr, 1'b0);
    wait_clks(3);
    reset = 1'b0;
    idle_ticks(20);
    check1("post_rst_idle", rxrdy, 1'b0);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    check8("post_rst_rdata", rdata, 8'h5A);
    check1("post_rst_rxrdy", rxrdy, 1'b1);
    check1("post_rst_ferr", framingerr, 1'b0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones
    do_reset();
    send_frame(8'h07, 1'b1, 1'b0);
    check1("par_bad", parityerr, 1'b1);
    pulse_read();
    idle_ticks(10);
    check1("par_hold", parityerr, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    check1("par_good", parityerr, 1'b0);
    check8("par_rdata", rdata, 8'h07);
`endif

    // Randomized frames at varying tick rates against the model
    do_reset();
    for (int n = 0; n < 40; n++) begin
      tick_div = $urandom_range(1, 3);
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pulse_read();
        model_read();
      end
      idle_ticks($urandom_range(4, 12));
      send_frame(d, stop, par);
      model_frame(d, stop, par);
      check_model($sformatf("rnd%0d", n));
      $display("[TB] rnd%0d div=%0d sent=%02h stop=%b par=%b rdata=%02h rxrdy=%b ferr=%b perr=%b ovr=%b",
               n, tick_div, d, stop, par, rdata, rxrdy, framingerr, parityerr, overrun);
    end
    tick_div = 1;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  function automatic logic d_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
